// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serialises per-core memory requests onto one
// single-port synchronous RAM and returns a one-cycle response per access.
module mem_arbiter #(
  parameter int WIDTH       = 32,
  parameter int NUM_CORES   = 4,
  parameter int IDX_WIDTH   = 2,
  parameter int ADDR_WIDTH  = 12,
  parameter int RAM_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CORES-1:0]       core_request,
  input  logic [NUM_CORES-1:0]       core_wren,
  input  logic [NUM_CORES*WIDTH-1:0] core_address,
  input  logic [NUM_CORES*WIDTH-1:0] core_writedata,
  output logic [NUM_CORES-1:0]       core_response,
  output logic [WIDTH-1:0]           core_readdata,
  output logic [ADDR_WIDTH-1:0]      ram_address,
  output logic                       ram_wren,
  output logic [WIDTH-1:0]           ram_writedata,
  input  logic [WIDTH-1:0]           ram_readdata,
  output logic                       busy,
  output logic [IDX_WIDTH-1:0]       grant_index
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;
  logic [IDX_WIDTH-1:0]   grant_q, grant_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   wren_q, wren_d;
  logic                   oor_q, oor_d;
  logic [ADDR_WIDTH-1:0]  ram_address_q, ram_address_d;
  logic [WIDTH-1:0]       ram_writedata_q, ram_writedata_d;
  logic                   ram_wren_q, ram_wren_d;
  logic [NUM_CORES-1:0]   core_response_q, core_response_d;
  logic [WIDTH-1:0]       core_readdata_q, core_readdata_d;
  logic                   busy_q, busy_d;

  logic [WIDTH-1:0]       addr_arr  [NUM_CORES];
  logic [WIDTH-1:0]       wdata_arr [NUM_CORES];
  logic [IDX_WIDTH-1:0]   winner;

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
      assign addr_arr[gi]  = core_address[gi*WIDTH +: WIDTH];
      assign wdata_arr[gi] = core_writedata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    logic [IDX_WIDTH:0] pos;
    winner = ptr_q;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_q} + (IDX_WIDTH+1)'(k);
      if (pos >= (IDX_WIDTH+1)'(NUM_CORES)) pos = pos - (IDX_WIDTH+1)'(NUM_CORES);
      if (core_request[pos[IDX_WIDTH-1:0]]) winner = pos[IDX_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    grant_d         = grant_q;
    cnt_d           = cnt_q;
    wren_d          = wren_q;
    oor_d           = oor_q;
    ram_address_d   = ram_address_q;
    ram_writedata_d = ram_writedata_q;
    ram_wren_d      = 1'b0;
    core_response_d = '0;
    core_readdata_d = core_readdata_q;
    case (state_q)
      IDLE: begin
        if (|core_request) begin
          grant_d         = winner;
          wren_d          = core_wren[winner];
          oor_d           = |addr_arr[winner][WIDTH-1:ADDR_WIDTH];
          ram_address_d   = addr_arr[winner][ADDR_WIDTH-1:0];
          ram_writedata_d = wdata_arr[winner];
          ram_wren_d      = core_wren[winner] & ~(|addr_arr[winner][WIDTH-1:ADDR_WIDTH]);
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        if (!wren_q && !oor_q) begin
          cnt_d   = 2'(RAM_LATENCY);
          state_d = WAIT;
        end else begin
          if (!wren_q) core_readdata_d = '0;
          core_response_d[grant_q] = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          core_readdata_d          = ram_readdata;
          core_response_d[grant_q] = 1'b1;
          state_d                  = RESP;
        end
      end
      RESP: begin
        ptr_d   = (grant_q == IDX_WIDTH'(NUM_CORES - 1)) ? '0 : grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      grant_q         <= '0;
      cnt_q           <= '0;
      wren_q          <= 1'b0;
      oor_q           <= 1'b0;
      ram_address_q   <= '0;
      ram_writedata_q <= '0;
      ram_wren_q      <= 1'b0;
      core_response_q <= '0;
      core_readdata_q <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      grant_q         <= grant_d;
      cnt_q           <= cnt_d;
      wren_q          <= wren_d;
      oor_q           <= oor_d;
      ram_address_q   <= ram_address_d;
      ram_writedata_q <= ram_writedata_d;
      ram_wren_q      <= ram_wren_d;
      core_response_q <= core_response_d;
      core_readdata_q <= core_readdata_d;
      busy_q          <= busy_d;
    end
  end

  assign core_response = core_response_q;
  assign core_readdata = core_readdata_q;
  assign ram_address   = ram_address_q;
  assign ram_wren      = ram_wren_q;
  assign ram_writedata = ram_writedata_q;
  assign busy          = busy_q;
  assign grant_index   = grant_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shared-memory responder for the multi-core cluster.
- Accepts the per-core memory request handshake (request, wren, address, writedata → response, readdata).
- Arbitrates round-robin among NUM_CORES cores and serialises accesses onto one single-port synchronous RAM.
- Returns each result to the issuing core as a one-cycle response pulse.
- Sits between the core array and the data RAM; replaces any direct core-to-RAM wiring.

Parameters:
- WIDTH, 32, data and core address width.
- NUM_CORES, 4, number of requesting cores; must be ≥2.
- IDX_WIDTH, 2, width of a core index; must equal clog2(NUM_CORES).
- ADDR_WIDTH, 12, RAM word-address width.
- RAM_LATENCY, 1, read latency of the RAM in cycles after the address is sampled; legal values 1..3.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- core_request  input  NUM_CORES  per-core request level; held high until that core's response.
- core_wren  input  NUM_CORES  per-core write enable; 1 = write, 0 = read.
- core_address  input  NUM_CORES*WIDTH  packed core addresses; core i occupies bits [i*WIDTH +: WIDTH].
- core_writedata  input  NUM_CORES*WIDTH  packed write data, same packing as core_address.
- core_response  output  NUM_CORES  one-hot, one-cycle completion pulse.
- core_readdata  output  WIDTH  read result; valid in the response cycle, shared by all cores.
- ram_address  output  ADDR_WIDTH  RAM address.
- ram_wren  output  1  RAM write strobe.
- ram_writedata  output  WIDTH  RAM write data.
- ram_readdata  input  WIDTH  RAM read data.
- busy  output  1  high whenever the arbiter is not in IDLE.
- grant_index  output  IDX_WIDTH  index of the core currently being served.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer ptr = 0; latency counter = 0.
- Reset mid-transaction: the transaction is abandoned and no response is issued. A RAM write already strobed stays done. The core keeps its request high and is re-served after reset.

FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any core_request bit is set, pick the winner g.
  - Selection: first set bit scanning ptr, ptr+1, …, wrapping modulo NUM_CORES.
  - Register grant_index = g, plus g's address, wren and writedata.
  - Go to ISSUE. If no request, stay in IDLE.
- ISSUE (one cycle): ram_address = latched address[ADDR_WIDTH-1:0]; ram_writedata = latched writedata.
  - ram_wren = 1 only if the latched wren = 1 and the address is in range.
  - Reads in range: go to WAIT with counter = RAM_LATENCY.
  - Writes, and out-of-range accesses: go to RESP.
- WAIT: decrement the counter each cycle. On the cycle it reaches 0, capture ram_readdata into core_readdata and go to RESP.
- RESP (one cycle): core_response[g] = 1. Set ptr = (g+1) mod NUM_CORES. Go to IDLE.
- Out-of-range: any of address bits [WIDTH-1:ADDR_WIDTH] nonzero.
  - No RAM write occurs.
  - A read returns core_readdata = 0.
  - A response is still issued.
- core_readdata holds its last value outside RESP, except that an out-of-range read clears it to 0.
- ram_wren is high only during ISSUE of an in-range write. ram_address and ram_writedata hold their values outside ISSUE.
- Latency: let t0 be the IDLE cycle in which the request is first seen.
  - Writes respond in t0+2.
  - In-range reads respond in t0+2+RAM_LATENCY.
  - The earliest next grant is the IDLE cycle t0+3 (writes) or t0+3+RAM_LATENCY (reads).
- The core drops its request in the cycle after response. The IDLE cycle following RESP must therefore not re-grant the same core, even if request is still high in the RESP cycle; the arbiter samples only in IDLE.
- Requests that change while not in IDLE are ignored until the next IDLE.
- A core's address, wren and writedata are sampled only in IDLE and are assumed stable while its request is high.
- Fairness: with all cores requesting continuously, grants follow 0,1,2,3,0,… with no core starved.

Test Plan:
1. Single write, then read:
   - Core 2 writes 0xDEADBEEF to address 0x10 → ram_wren pulses once with ram_address 0x010; core_response = 4'b0100 at t0+2.
   - Core 2 then reads 0x10 → core_readdata = 0xDEADBEEF with response at t0+3 (RAM_LATENCY = 1).
2. Contention: all four cores request reads in the same cycle with ptr = 0 → responses in order core 0, 1, 2, 3, each one-hot, never overlapping. ptr ends at 0.
3. Round-robin wrap: ptr = 3 (after serving core 2); cores 0 and 3 request → core 3 served first, then core 0.
4. Out-of-range: core 1 writes to 0x0001_0000 → no ram_wren, response at t0+2. Core 1 reads the same address → core_readdata = 0.
5. Reset during WAIT of a read by core 0 → no response and all outputs 0. After reset deasserts, core 0 (still requesting) is re-served and receives correct data.
6. RAM_LATENCY = 3 build: a read returns the correct data with response at exactly t0+5; busy stays high from t0+1 through t0+5.
